fetch_sequencer: RTL and testbench

//   Drives the F-stage PC register and sequences instruction fetch over a req/ack

---
 rtl/fetch_sequencer_pkg.sv | 22 ++
 rtl/fetch_sequencer.sv | 109 ++++++++++
 tb/tb_fetch_sequencer.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_sequencer_pkg.sv
// Shared fetch-stage definitions: FSM encodings, reset PC, text-segment bounds, NOP.
// Reused by the fetch sequencer, the hazard unit and the bench.
package fetch_sequencer_pkg;

  typedef enum logic {
    S_FETCH = 1'b0,
    S_VALID = 1'b1
  } fetch_state_e;

  localparam logic [31:0] RESET_PC_DEF = 32'h0000_3000;
  localparam logic [31:0] TEXT_LO_DEF  = 32'h0000_3000;
  localparam logic [31:0] TEXT_HI_DEF  = 32'h0000_6FFC;
  localparam logic [31:0] NOP          = 32'h0000_0000;

  // Word-aligned and inside the inclusive text window.
  function automatic logic addr_legal(input logic [31:0] pc,
                                      input logic [31:0] lo,
                                      input logic [31:0] hi);
    return (pc[1:0] == 2'b00) && (pc >= lo) && (pc <= hi);
  endfunction

endpackage

// File: rtl/fetch_sequencer.sv
// F-stage PC register and req/ack instruction fetch sequencer with MIPS delay-slot redirects.
// Optional fetch address-error checking is enabled by defining FETCH_ADEL_EN.
//
// Handshake: imem_req stays high with imem_addr stable until a cycle where
// imem_ack=1 (ack is ignored whenever imem_req=0); F_valid offers F_instr and is
// consumed on any cycle with stall=0.
module fetch_sequencer
  import fetch_sequencer_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF
`ifdef FETCH_ADEL_EN
  ,
  parameter logic [31:0] TEXT_LO  = TEXT_LO_DEF,
  parameter logic [31:0] TEXT_HI  = TEXT_HI_DEF
`endif
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         stall,
  input  logic         redirect_valid,
  input  logic [31:0]  redirect_pc,
  output logic         imem_req,
  output logic [31:0]  imem_addr,
  input  logic         imem_ack,
  input  logic [31:0]  imem_rdata,
  output logic [31:0]  F_PC,
  output logic [31:0]  F_instr,
  output logic         F_valid,
  output logic         F_exc_adel,
  output fetch_state_e fsm_state
);

  fetch_state_e state;
  logic         live;
  logic [31:0]  pc;
  logic [31:0]  pend_pc;
  logic         pend_valid;
  logic [31:0]  buffer;
  logic         fetch_ok;
  logic [31:0]  next_pc;

`ifdef FETCH_ADEL_EN
  logic exc_q;

  assign fetch_ok   = addr_legal(pc, TEXT_LO, TEXT_HI);
  assign imem_addr  = pc;
  assign F_exc_adel = (state == S_VALID) && exc_q;
`else
  assign fetch_ok   = 1'b1;
  assign imem_addr  = {pc[31:2], 2'b00};
  assign F_exc_adel = 1'b0;
`endif

  // live holds the request off for the reset cycle and the first edge after it.
  assign imem_req  = live && (state == S_FETCH) && fetch_ok;
  assign F_valid   = (state == S_VALID);
  assign F_instr   = (state == S_VALID) ? buffer : NOP;
  assign F_PC      = pc;
  assign fsm_state = state;

  assign next_pc = redirect_valid ? redirect_pc :
                   pend_valid     ? pend_pc     :
                                    pc + 32'd4;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_FETCH;
      live       <= 1'b0;
      pc         <= RESET_PC;
      pend_pc    <= 32'h0;
      pend_valid <= 1'b0;
      buffer     <= NOP;
`ifdef FETCH_ADEL_EN
      exc_q      <= 1'b0;
`endif
    end else begin
      live <= 1'b1;
      case (state)
        S_FETCH: begin
          // The outstanding fetch is the delay slot; the target waits in pend_pc.
          if (!stall && redirect_valid) begin
            pend_valid <= 1'b1;
            pend_pc    <= redirect_pc;
          end
          if (imem_req && imem_ack) begin
            buffer <= imem_rdata;
            state  <= S_VALID;
`ifdef FETCH_ADEL_EN
            exc_q  <= 1'b0;
          end else if (live && !fetch_ok) begin
            buffer <= NOP;
            exc_q  <= 1'b1;
            state  <= S_VALID;
`endif
          end
        end
        S_VALID: begin
          if (!stall) begin
            state      <= S_FETCH;
            pc         <= next_pc;
            pend_valid <= 1'b0;
          end
        end
        default: state <= S_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed, table-driven bench for fetch_sequencer plus hand sequences for reset-mid-fetch
// and (when FETCH_ADEL_EN is defined) fetch address errors.
module tb_fetch_sequencer;
  import fetch_sequencer_pkg::*;

  logic         clk;
  logic         reset;
  logic         stall;
  logic         redirect_valid;
  logic [31:0]  redirect_pc;
  logic         imem_req;
  logic [31:0]  imem_addr;
  logic         imem_ack;
  logic [31:0]  imem_rdata;
  logic [31:0]  F_PC;
  logic [31:0]  F_instr;
  logic         F_valid;
  logic         F_exc_adel;
  fetch_state_e fsm_state;

  int errors;
  int checks;

  typedef struct {
    logic        stall;
    logic        rv;
    logic [31:0] rpc;
    logic        ack;
    logic [31:0] rdata;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_valid;
    logic [31:0] e_instr;
    logic [31:0] e_pc;
  } vec_t;

  vec_t tbl[$];

  fetch_sequencer dut (
    .clk            (clk),
    .reset          (reset),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ack       (imem_ack),
    .imem_rdata     (imem_rdata),
    .F_PC           (F_PC),
    .F_instr        (F_instr),
    .F_valid        (F_valid),
    .F_exc_adel     (F_exc_adel),
    .fsm_state      (fsm_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] ins(input int k);
    return 32'h8C00_0000 | k;
  endfunction

  // Fetch cycle: request at addr expected, F_valid low.
  task automatic vf(input logic [31:0] addr, input logic ack, input logic [31:0] rdata,
                    input logic st, input logic rv, input logic [31:0] rpc);
    vec_t v;
    v.stall = st; v.rv = rv; v.rpc = rpc; v.ack = ack; v.rdata = rdata;
    v.e_req = 1'b1; v.e_addr = addr; v.e_valid = 1'b0; v.e_instr = NOP; v.e_pc = addr;
    tbl.push_back(v);
  endtask

  // Valid cycle: instruction offered, no request.
  task automatic vv(input logic [31:0] pc, input logic [31:0] instr,
                    input logic st, input logic rv, input logic [31:0] rpc);
    vec_t v;
    v.stall = st; v.rv = rv; v.rpc = rpc; v.ack = 1'b0; v.rdata = 32'hDEAD_BEEF;
    v.e_req = 1'b0; v.e_addr = pc; v.e_valid = 1'b1; v.e_instr = instr; v.e_pc = pc;
    tbl.push_back(v);
  endtask

  task automatic drive(input logic st, input logic rv, input logic [31:0] rpc,
                       input logic ack, input logic [31:0] rdata);
    stall = st; redirect_valid = rv; redirect_pc = rpc; imem_ack = ack; imem_rdata = rdata;
  endtask

  initial begin
    errors = 0;
    checks = 0;
    reset  = 1'b1;
    drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);

    // sequential fetch, ack on the second request cycle
    vf(32'h3000, 0, 0,      0, 0, 0);
    vf(32'h3000, 1, ins(0), 0, 0, 0);
    vv(32'h3000, ins(0),    0, 0, 0);
    vf(32'h3004, 0, 0,      0, 0, 0);
    vf(32'h3004, 1, ins(1), 0, 0, 0);
    vv(32'h3004, ins(1),    0, 0, 0);
    vf(32'h3008, 0, 0,      0, 0, 0);
    vf(32'h3008, 1, ins(2), 0, 0, 0);
    // three stall cycles hold the instruction
    vv(32'h3008, ins(2),    1, 0, 0);
    vv(32'h3008, ins(2),    1, 0, 0);
    vv(32'h3008, ins(2),    1, 0, 0);
    vv(32'h3008, ins(2),    0, 0, 0);
    vf(32'h300C, 1, ins(3), 0, 0, 0);
    vv(32'h300C, ins(3),    0, 0, 0);
    vf(32'h3010, 1, ins(4), 0, 0, 0);
    vv(32'h3010, ins(4),    0, 0, 0);
    // branch at 0x3010 redirects while its delay slot 0x3014 is outstanding
    vf(32'h3014, 0, 0,      0, 1, 32'h3100);
    vf(32'h3014, 0, 0,      0, 0, 0);
    vf(32'h3014, 1, ins(5), 0, 0, 0);
    vv(32'h3014, ins(5),    0, 0, 0);
    vf(32'h3100, 1, ins(6), 0, 0, 0);
    // redirects taken directly in S_VALID
    vv(32'h3100, ins(6),    0, 1, 32'h3020);
    vf(32'h3020, 1, ins(7), 0, 0, 0);
    vv(32'h3020, ins(7),    0, 1, 32'h3200);
    vf(32'h3200, 1, ins(8), 0, 0, 0);
    vv(32'h3200, ins(8),    0, 1, 32'h3020);
    vf(32'h3020, 1, ins(9), 0, 0, 0);
    // redirect under stall is ignored, in both states
    vv(32'h3020, ins(9),    1, 1, 32'h3300);
    vv(32'h3020, ins(9),    0, 0, 0);
    vf(32'h3024, 0, 0,      1, 1, 32'h3400);
    vf(32'h3024, 1, ins(10), 0, 0, 0);
    vv(32'h3024, ins(10),   0, 0, 0);
`ifndef FETCH_ADEL_EN
    // pc+4 wraps modulo 2^32
    vf(32'h3028, 1, ins(11), 0, 0, 0);
    vv(32'h3028, ins(11),   0, 1, 32'hFFFF_FFFC);
    vf(32'hFFFF_FFFC, 1, ins(12), 0, 0, 0);
    vv(32'hFFFF_FFFC, ins(12), 0, 0, 0);
    vf(32'h0000_0000, 0, 0, 0, 0, 0);
`else
    vf(32'h3028, 0, 0,      0, 0, 0);
`endif

    // reset state
    #2;
    chk("rst_req",   {31'h0, imem_req},   32'h0);
    chk("rst_valid", {31'h0, F_valid},    32'h0);
    chk("rst_instr", F_instr,             32'h0);
    chk("rst_pc",    F_PC,                32'h3000);
    chk("rst_adel",  {31'h0, F_exc_adel}, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);

    foreach (tbl[i]) begin
      @(negedge clk);
      chk($sformatf("v%0d_req", i), {31'h0, imem_req}, {31'h0, tbl[i].e_req});
      if (tbl[i].e_req)
        chk($sformatf("v%0d_addr", i), imem_addr, tbl[i].e_addr);
      chk($sformatf("v%0d_valid", i), {31'h0, F_valid}, {31'h0, tbl[i].e_valid});
      chk($sformatf("v%0d_instr", i), F_instr, tbl[i].e_instr);
      chk($sformatf("v%0d_pc", i), F_PC, tbl[i].e_pc);
      chk($sformatf("v%0d_adel", i), {31'h0, F_exc_adel}, 32'h0);
      drive(tbl[i].stall, tbl[i].rv, tbl[i].rpc, tbl[i].ack, tbl[i].rdata);
    end

    // reset while a request is outstanding; a late ack must be ignored
    @(negedge clk);
    chk("mid_req_before", {31'h0, imem_req}, 32'h1);
    reset = 1'b1;
    drive(1'b0, 1'b0, 32'h0, 1'b1, 32'hBAD0_BAD0);
    #1;
    chk("mid_req_drop", {31'h0, imem_req}, 32'h0);
    chk("mid_valid",    {31'h0, F_valid},  32'h0);
    chk("mid_pc",       F_PC,              32'h3000);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("post_valid", {31'h0, F_valid},  32'h0);
    chk("post_req",   {31'h0, imem_req}, 32'h1);
    chk("post_addr",  imem_addr,         32'h3000);
    imem_ack = 1'b0;
    @(negedge clk);
    chk("post_valid2", {31'h0, F_valid}, 32'h0);
    chk("post_req2",   {31'h0, imem_req}, 32'h1);
    drive(1'b0, 1'b0, 32'h0, 1'b1, 32'hCAFE_0001);
    @(negedge clk);
    chk("refetch_valid", {31'h0, F_valid}, 32'h1);
    chk("refetch_instr", F_instr,          32'hCAFE_0001);
    chk("refetch_pc",    F_PC,             32'h3000);
`ifdef FETCH_ADEL_EN
    // misaligned redirect target: no request, exception slot delivered instead
    drive(1'b0, 1'b1, 32'h3002, 1'b0, 32'h0);
    @(negedge clk);
    chk("adel_req", {31'h0, imem_req}, 32'h0);
    chk("adel_pc",  F_PC,              32'h3002);
    drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    @(negedge clk);
    chk("adel_valid", {31'h0, F_valid},    32'h1);
    chk("adel_flag",  {31'h0, F_exc_adel}, 32'h1);
    chk("adel_instr", F_instr,             32'h0);
    @(negedge clk);
    chk("adel2_req", {31'h0, imem_req}, 32'h0);
    chk("adel2_pc",  F_PC,              32'h3006);
    @(negedge clk);
    chk("adel2_valid", {31'h0, F_valid},    32'h1);
    chk("adel2_flag",  {31'h0, F_exc_adel}, 32'h1);
    chk("adel2_instr", F_instr,             32'h0);
`else
    drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    @(negedge clk);
    chk("next_req",  {31'h0, imem_req}, 32'h1);
    chk("next_addr", imem_addr,         32'h3004);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
